// File: rtl/gin_mc_bus.sv
// Multicast bus: routes each tagged input packet to every enabled slave whose ID
// matches the tag (or all enabled slaves on the broadcast tag), with per-slave FIFOs.
`timescale 1ns/1ps

module gin_mc_bus #(
  parameter int unsigned ID_BITWIDTH   = 4,
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned SLV_NUM       = 6,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [ID_BITWIDTH+DATA_BITWIDTH-1:0] i_packet,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [SLV_NUM*DATA_BITWIDTH-1:0]   o_packet,
  output logic [SLV_NUM-1:0]                 o_valid,
  input  logic [SLV_NUM-1:0]                 i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]     i_id,
  input  logic [SLV_NUM-1:0]                 i_en_mask,
  input  logic                               i_id_valid,
  output logic [15:0]                        o_drop_cnt,
  output logic                               o_idle
);

  localparam int unsigned IW    = ID_BITWIDTH;
  localparam int unsigned DW    = DATA_BITWIDTH;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [IW-1:0] BCAST = '1;

  logic [IW-1:0]    id_r   [SLV_NUM];
  logic [SLV_NUM-1:0] en_r;
  logic [DW-1:0]    mem    [SLV_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [SLV_NUM];
  logic [PTR_W-1:0] rd_ptr [SLV_NUM];
  logic [CNT_W-1:0] cnt    [SLV_NUM];

  logic [SLV_NUM-1:0] full, empty, match, push, pop;
  logic [IW-1:0]      tag;
  logic               accept;

  // Routing decode and handshake; ready ignores disabled slaves' fullness
  always_comb begin
    tag     = i_packet[DW +: IW];
    full    = '0;
    empty   = '0;
    match   = '0;
    o_packet = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      full[k]  = (cnt[k] == CNT_W'(FIFO_DEPTH));
      empty[k] = (cnt[k] == '0);
      match[k] = en_r[k] & ((tag == id_r[k]) | (tag == BCAST));
      o_packet[k*DW +: DW] = mem[k][rd_ptr[k]];
    end
    o_ready = ~i_id_valid & ~|(en_r & full);
    accept  = i_valid & o_ready;
    push    = {SLV_NUM{accept}} & match & ~full;
    pop     = ~empty & i_ready;
    o_valid = ~empty;
    o_idle  = &empty;
  end

  // Configuration registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_r <= '0;
      for (int k = 0; k < SLV_NUM; k++) id_r[k] <= '0;
    end else if (i_id_valid) begin
      en_r <= i_en_mask;
      for (int k = 0; k < SLV_NUM; k++) id_r[k] <= i_id[k*IW +: IW];
    end
  end

  // Per-slave FIFOs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SLV_NUM; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) mem[k][d] <= '0;
      end
    end else begin
      for (int k = 0; k < SLV_NUM; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= i_packet[DW-1:0];
          wr_ptr[k]         <= wr_ptr[k] + PTR_W'(1);
        end
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + CNT_W'(1);
          2'b01:   cnt[k] <= cnt[k] - CNT_W'(1);
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Saturating count of accepted packets with no destination
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
    end else if (accept && (match == '0) && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gin_mc_bus.sv
// Directed bench for gin_mc_bus with a per-slave expected-data scoreboard.
`timescale 1ns/1ps

module tb_gin_mc_bus;

  localparam int unsigned IW  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned NS  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IW+DW-1:0]  i_packet;
  logic              i_valid;
  logic              o_ready;
  logic [NS*DW-1:0]  o_packet;
  logic [NS-1:0]     o_valid;
  logic [NS-1:0]     i_ready;
  logic [NS*IW-1:0]  i_id;
  logic [NS-1:0]     i_en_mask;
  logic              i_id_valid;
  logic [15:0]       o_drop_cnt;
  logic              o_idle;

  gin_mc_bus #(.ID_BITWIDTH(IW), .DATA_BITWIDTH(DW), .SLV_NUM(NS), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_packet(i_packet), .i_valid(i_valid),
    .o_ready(o_ready), .o_packet(o_packet), .o_valid(o_valid), .i_ready(i_ready),
    .i_id(i_id), .i_en_mask(i_en_mask), .i_id_valid(i_id_valid),
    .o_drop_cnt(o_drop_cnt), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_q [NS][$];
  logic [IW-1:0] id_m  [NS];
  logic [NS-1:0] en_m;
  int            drop_m;

  localparam logic [NS*IW-1:0] IDS_BASE = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [NS*IW-1:0] IDS_ALT  = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model of the routing decision for an accepted packet
  task automatic model_accept(input logic [IW-1:0] tag, input logic [DW-1:0] data);
    bit hit = 0;
    for (int k = 0; k < NS; k++) begin
      if (en_m[k] && (tag == id_m[k] || tag == 4'hF)) begin
        exp_q[k].push_back(data);
        hit = 1;
      end
    end
    if (!hit) drop_m++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      exp_q[k].delete();
      id_m[k] = '0;
    end
    en_m   = '0;
    drop_m = 0;
  endtask

  task automatic cfg(input logic [NS*IW-1:0] ids, input logic [NS-1:0] en);
    @(posedge clk); #1;
    i_id = ids; i_en_mask = en; i_id_valid = 1'b1;
    @(posedge clk); #1;
    i_id_valid = 1'b0;
    for (int k = 0; k < NS; k++) id_m[k] = ids[k*IW +: IW];
    en_m = en;
  endtask

  task automatic send(input logic [IW-1:0] tag, input logic [DW-1:0] data);
    bit ok = 0;
    @(posedge clk); #1;
    i_packet = {tag, data};
    i_valid  = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (o_ready) ok = 1;
    end
    if (ok) model_accept(tag, data);
    else begin
      n_chk++;
      $display("FAIL send_timeout: tag %0d never accepted, o_ready=%0b expected 1", tag, o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Monitor: every slave transfer is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NS; k++) begin
        if (o_valid[k] && i_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++;
            $display("FAIL slv%0d_unexpected: got data 0x%0h expected no transfer", k, o_packet[k*DW +: DW]);
          end else begin
            chk($sformatf("slv%0d_data", k), 32'(o_packet[k*DW +: DW]), 32'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; i_packet = '0; i_valid = 1'b0; i_ready = '1;
    i_id = '0; i_en_mask = '0; i_id_valid = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_idle", 32'(o_idle), 32'h1);
    chk("rst_drop", 32'(o_drop_cnt), 32'h0);
    chk("rst_packet", 32'(o_packet), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Unicast
    cfg(IDS_BASE, 6'b111111);
    send(4'd2, 8'h11);
    @(negedge clk); chk("uni_valid", 32'(o_valid), 32'b000100);
    @(negedge clk); chk("uni_valid_gone", 32'(o_valid), 32'h0);

    // Broadcast, then with slave 4 disabled
    send(4'hF, 8'hA5);
    @(negedge clk); chk("bc_valid", 32'(o_valid), 32'b111111);
    cfg(IDS_BASE, 6'b101111);
    send(4'hF, 8'h5A);
    @(negedge clk); chk("bc_masked_valid", 32'(o_valid), 32'b101111);

    // Backpressure on slave 3
    cfg(IDS_BASE, 6'b111111);
    @(posedge clk); #1 i_ready[3] = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, 8'h30 + 8'(i));
    @(negedge clk); chk("bp_ready_full", 32'(o_ready), 32'h0);
    fork
      send(4'd0, 8'h0C);
      begin
        repeat (3) @(negedge clk);
        chk("bp_held_slv0", 32'(o_valid[0]), 32'h0);
        chk("bp_held_ready", 32'(o_ready), 32'h0);
        @(posedge clk); #1 i_ready[3] = 1'b1;
        @(negedge clk); chk("bp_no_writethrough", 32'(o_ready), 32'h0);
      end
    join
    repeat (8) @(negedge clk);
    chk("bp_idle", 32'(o_idle), 32'h1);

    // Drop
    send(4'd7, 8'h77);
    @(negedge clk);
    chk("drop_valid", 32'(o_valid), 32'h0);
    chk("drop_ready", 32'(o_ready), 32'h1);
    chk("drop_cnt", 32'(o_drop_cnt), 32'(drop_m));

    // Config collision: packet must wait and route under the new IDs
    @(posedge clk); #1;
    i_id = IDS_ALT; i_en_mask = 6'b111111; i_id_valid = 1'b1;
    i_packet = {4'd9, 8'h99}; i_valid = 1'b1;
    @(negedge clk); chk("col_ready_low", 32'(o_ready), 32'h0);
    @(posedge clk); #1 i_id_valid = 1'b0;
    for (int k = 0; k < NS; k++) id_m[k] = IDS_ALT[k*IW +: IW];
    @(negedge clk); chk("col_ready_high", 32'(o_ready), 32'h1);
    model_accept(4'd9, 8'h99);
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    chk("col_valid", 32'(o_valid), 32'b000001);
    chk("col_drop", 32'(o_drop_cnt), 32'(drop_m));

    // Asynchronous reset with queued data
    cfg(IDS_BASE, 6'b111111);
    @(posedge clk); #1 i_ready[1] = 1'b0;
    send(4'd1, 8'hC1);
    send(4'd1, 8'hC2);
    @(negedge clk); chk("ar_pre_valid", 32'(o_valid), 32'b000010);
    @(posedge clk); #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", 32'(o_valid), 32'h0);
    chk("ar_idle", 32'(o_idle), 32'h1);
    chk("ar_drop", 32'(o_drop_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; i_ready = '1;
    cfg(IDS_BASE, 6'b111111);
    send(4'd1, 8'hD1);
    @(negedge clk); chk("ar_post_valid", 32'(o_valid), 32'b000010);
    repeat (4) @(negedge clk);

    for (int k = 0; k < NS; k++) chk($sformatf("slv%0d_drained", k), 32'(exp_q[k].size()), 32'h0);
    chk("final_idle", 32'(o_idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gin_mc_bus.md
GIN_MC_BUS -- requirements
Module: gin_mc_bus

Interface
REQ-001 SHALL have parameter ID_BITWIDTH, default 4: tag/ID width; the all-ones tag is reserved as BCAST.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 8: payload width per slave.
REQ-003 SHALL have parameter SLV_NUM, default 6: number of slave ports.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: entries per slave output FIFO; a power of two, at least 2.
REQ-005 SHALL have port i_clk  in  1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port i_rst_n  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_packet  in  ID_BITWIDTH+DATA_BITWIDTH: {tag, data}, tag in the MSBs.
REQ-008 SHALL have ports i_valid  in  1 and o_ready  out  1: input valid/ready handshake.
REQ-009 SHALL have port o_packet  out  SLV_NUM*DATA_BITWIDTH: slave k data on bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
REQ-010 SHALL have ports o_valid  out  SLV_NUM and i_ready  in  SLV_NUM: per-slave handshake.
REQ-011 SHALL have port i_id  in  SLV_NUM*ID_BITWIDTH: slave k ID on bits [k*ID_BITWIDTH +: ID_BITWIDTH].
REQ-012 SHALL have port i_en_mask  in  SLV_NUM: per-slave enable, loaded together with the IDs.
REQ-013 SHALL have port i_id_valid  in  1: configuration load strobe.
REQ-014 SHALL have port o_drop_cnt  out  16: count of accepted packets that matched no slave.
REQ-015 SHALL have port o_idle  out  1: high when all slave FIFOs are empty.

Function
REQ-016 SHALL capture i_id and i_en_mask into internal registers on the edge where i_id_valid=1; the new values apply from the next cycle.
REQ-017 SHALL drive o_ready = ~i_id_valid AND (every slave FIFO with en[k]=1 is not full); o_ready SHALL NOT depend on i_valid or i_packet.
REQ-018 SHALL accept a packet on an edge where i_valid & o_ready = 1; i_packet is sampled only at that edge.
REQ-019 SHALL compute match[k] = en[k] & (tag==id[k] | tag==BCAST) for each accepted packet.
REQ-020 SHALL push data (tag stripped) into FIFO k for every k with match[k]=1, all on the same edge (all-or-nothing multicast).
REQ-021 SHALL, for an accepted packet with match=0, write no FIFO and increment o_drop_cnt, saturating at 16'hFFFF.
REQ-022 SHALL drive o_valid[k] = FIFO k non-empty and o_packet slice k = FIFO k head; the head pops on an edge where o_valid[k] & i_ready[k] = 1.
REQ-023 SHALL deliver with 1-cycle latency: a packet accepted at edge N gives o_valid high in the cycle following edge N when the FIFO was empty.
REQ-024 SHALL preserve order per slave; slave ports drain independently, so one stalled slave blocks input only once its FIFO is full.
REQ-025 SHALL NOT write through a full FIFO: a simultaneous pop on a full FIFO does not raise o_ready in that cycle.
REQ-026 SHALL handle simultaneous push and pop on a non-full, non-empty FIFO with count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 SHALL NOT flush FIFOs on reconfiguration; already-queued data drains to its original slave.
REQ-028 SHALL use a disabled slave's FIFO fullness only for its own draining; it never blocks o_ready and never receives pushes.
REQ-029 SHALL treat a configured ID equal to BCAST as matching broadcast tags only.

Reset
REQ-030 SHALL, while i_rst_n=0 and independent of i_clk: empty all FIFOs and clear pointers; set o_valid=0, o_packet=0, o_drop_cnt=0, o_idle=1, en=0 and all IDs=0; o_ready follows REQ-017.
REQ-031 SHALL on reset assertion mid-operation discard queued data immediately with no partial pops; the first accept after release is a clean transfer.

Verification
REQ-032 Bench SHALL cover unicast: config IDs {5,4,3,2,1,0}, en=6'b111111; send {4'd2, 8'h11} with i_ready all ones -> o_valid=6'b000100 for exactly one cycle, slice 2 = 8'h11.
REQ-033 Bench SHALL cover broadcast: send {4'hF, 8'hA5} -> o_valid=6'b111111 the next cycle, all slices 8'hA5; then en=6'b101111 -> repeat gives o_valid=6'b101111.
REQ-034 Bench SHALL cover backpressure: i_ready[3]=0, send 4 packets with tag 3 -> o_ready=0 after the 4th accept, and a tag-0 packet is held; raise i_ready[3] -> slice 3 outputs in order, then the tag-0 packet is accepted.
REQ-035 Bench SHALL cover drop: send tag 7 (no owner) -> o_valid stays 0, o_ready stays 1, o_drop_cnt=1.
REQ-036 Bench SHALL cover config collision: i_id_valid=1 with i_valid=1 -> no accept that cycle, packet accepted the next cycle under the new IDs.
REQ-037 Bench SHALL cover async reset: pull i_rst_n low mid-clock with FIFOs non-empty -> o_valid=0 and o_idle=1 before the next edge, o_drop_cnt=0.
